// File: rtl/bc_pkg.sv
// Shared definitions for the bus-connect output block: destination codes
// and the default datapath width.
package bc_pkg;

    localparam int BC_DW = 16;

    typedef enum logic [1:0] {
        BC_DST_DM   = 2'b00,
        BC_DST_PS   = 2'b01,
        BC_DST_XB   = 2'b10,
        BC_DST_NONE = 2'b11
    } bc_dst_e;

endpackage

// File: rtl/bc_xb_fifo.sv
// Synchronous FIFO for the external-bus transmit path. The head entry is held
// in its own register so the output is flop-driven and stable under back-pressure.
module bc_xb_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   cnt
);

    localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE_C = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE_C = AW'(1);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] rd_nxt_s;
    logic [AW:0]   cnt_r;
    logic [W-1:0]  head_r;
    logic [W-1:0]  head_nxt_s;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign empty = (cnt_r == {(AW+1){1'b0}});
    assign full  = (cnt_r == DEPTH_C);
    assign cnt   = cnt_r;
    assign dout  = head_r;

    // Qualify requests and select the next head entry.
    always_comb begin
        push_ok_s  = push & ~full;
        pop_ok_s   = pop & ~empty;
        rd_nxt_s   = rd_ptr_r + PTR_ONE_C;
        head_nxt_s = head_r;
        if (pop_ok_s) begin
            // With one entry left, a concurrent push lands exactly at the new head.
            if (cnt_r > CNT_ONE_C) begin
                head_nxt_s = mem_r[rd_nxt_s];
            end else if (push_ok_s) begin
                head_nxt_s = din;
            end else begin
                head_nxt_s = head_r;
            end
        end else if (push_ok_s && empty) begin
            head_nxt_s = din;
        end else begin
            head_nxt_s = head_r;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            cnt_r    <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_nxt_s;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_r <= cnt_r + CNT_ONE_C;
                2'b01:   cnt_r <= cnt_r - CNT_ONE_C;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Entry storage and head register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
            head_r <= {W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
            end
            head_r <= head_nxt_s;
        end
    end

endmodule

// File: rtl/bc_dout.sv
// Bus-connect output router: register-file data to DM, PS/DAG or xb FIFO.
// Optional build macro BC_XB_PARITY_EN adds a per-entry parity bit on bc_xb_par.
module bc_dout
    import bc_pkg::*;
#(
    parameter int DW       = BC_DW,
    parameter int XB_DEPTH = 4,
    parameter int XB_AW    = 2
) (
    input  logic             clk_dcd,
    input  logic             reset,
    input  logic [DW-1:0]    rf_bc_dt,
    input  logic             ps_bc_do_en,
    input  logic [1:0]       ps_bc_do_sclt,
    output logic [DW-1:0]    bc_dm_dt,
    output logic             bc_dm_wen,
    output logic [DW-1:0]    bc_ps_dt,
    output logic             bc_ps_wen,
    output logic [DW-1:0]    bc_xb_dt,
    output logic             bc_xb_vld,
    input  logic             xb_bc_rdy,
    output logic             bc_ps_stall,
`ifdef BC_XB_PARITY_EN
    output logic             bc_xb_par,
`endif
    output logic [XB_AW:0]   bc_xb_cnt
);

`ifdef BC_XB_PARITY_EN
    localparam int FW = DW + 1;

    function automatic logic even_par(input logic [DW-1:0] d);
        return ^d;
    endfunction
`else
    localparam int FW = DW;
`endif

    logic          dm_sel_s;
    logic          ps_sel_s;
    logic          xb_req_s;
    logic          xb_push_s;
    logic          xb_pop_s;
    logic          xb_empty_s;
    logic          xb_full_s;
    logic [FW-1:0] xb_din_s;
    logic [FW-1:0] xb_dout_s;

    // Destination decode; only the listed codes strobe anything.
    always_comb begin
        dm_sel_s = 1'b0;
        ps_sel_s = 1'b0;
        xb_req_s = 1'b0;
        if (ps_bc_do_en) begin
            case (bc_dst_e'(ps_bc_do_sclt))
                BC_DST_DM:   dm_sel_s = 1'b1;
                BC_DST_PS:   ps_sel_s = 1'b1;
                BC_DST_XB:   xb_req_s = 1'b1;
                BC_DST_NONE: xb_req_s = 1'b0;
                default:     xb_req_s = 1'b0;
            endcase
        end else begin
            xb_req_s = 1'b0;
        end
    end

    assign bc_ps_stall = xb_full_s;
    assign bc_xb_vld   = ~xb_empty_s;
    assign xb_push_s   = xb_req_s & ~xb_full_s;
    assign xb_pop_s    = bc_xb_vld & xb_bc_rdy;

`ifdef BC_XB_PARITY_EN
    assign xb_din_s  = {even_par(rf_bc_dt), rf_bc_dt};
    assign bc_xb_dt  = xb_dout_s[DW-1:0];
    assign bc_xb_par = xb_dout_s[DW];
`else
    assign xb_din_s  = rf_bc_dt;
    assign bc_xb_dt  = xb_dout_s;
`endif

    // DM and PS write ports: one-cycle strobe, data held between writes.
    always_ff @(posedge clk_dcd or posedge reset) begin
        if (reset) begin
            bc_dm_dt  <= {DW{1'b0}};
            bc_dm_wen <= 1'b0;
            bc_ps_dt  <= {DW{1'b0}};
            bc_ps_wen <= 1'b0;
        end else begin
            bc_dm_wen <= dm_sel_s;
            bc_ps_wen <= ps_sel_s;
            if (dm_sel_s) begin
                bc_dm_dt <= rf_bc_dt;
            end
            if (ps_sel_s) begin
                bc_ps_dt <= rf_bc_dt;
            end
        end
    end

    bc_xb_fifo #(
        .W     (FW),
        .DEPTH (XB_DEPTH),
        .AW    (XB_AW)
    ) u_xb_fifo (
        .clk   (clk_dcd),
        .rst   (reset),
        .push  (xb_push_s),
        .din   (xb_din_s),
        .pop   (xb_pop_s),
        .dout  (xb_dout_s),
        .empty (xb_empty_s),
        .full  (xb_full_s),
        .cnt   (bc_xb_cnt)
    );

endmodule

// File: tb/tb_bc_dout.sv
// Self-checking bench for bc_dout: queue-based reference model, per-cycle
// compare on the falling edge, directed scenarios plus random traffic.
module tb_bc_dout;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk_dcd = 1'b0;
    logic          reset   = 1'b1;
    logic [DW-1:0] rf_bc_dt = '0;
    logic          ps_bc_do_en = 1'b0;
    logic [1:0]    ps_bc_do_sclt = 2'b00;
    logic          xb_bc_rdy = 1'b0;
    logic [DW-1:0] bc_dm_dt, bc_ps_dt, bc_xb_dt;
    logic          bc_dm_wen, bc_ps_wen, bc_xb_vld, bc_ps_stall;
    logic [AW:0]   bc_xb_cnt;
`ifdef BC_XB_PARITY_EN
    logic          bc_xb_par;
`endif

    bc_dout #(.DW(DW), .XB_DEPTH(DEPTH), .XB_AW(AW)) dut (
        .clk_dcd       (clk_dcd),
        .reset         (reset),
        .rf_bc_dt      (rf_bc_dt),
        .ps_bc_do_en   (ps_bc_do_en),
        .ps_bc_do_sclt (ps_bc_do_sclt),
        .bc_dm_dt      (bc_dm_dt),
        .bc_dm_wen     (bc_dm_wen),
        .bc_ps_dt      (bc_ps_dt),
        .bc_ps_wen     (bc_ps_wen),
        .bc_xb_dt      (bc_xb_dt),
        .bc_xb_vld     (bc_xb_vld),
        .xb_bc_rdy     (xb_bc_rdy),
        .bc_ps_stall   (bc_ps_stall),
`ifdef BC_XB_PARITY_EN
        .bc_xb_par     (bc_xb_par),
`endif
        .bc_xb_cnt     (bc_xb_cnt)
    );

    always #5 clk_dcd = ~clk_dcd;

    // Reference model: FIFO contents as a queue of {parity, data}.
    logic [DW:0]   m_q[$];
    logic [DW-1:0] m_dm_dt = '0, m_ps_dt = '0;
    logic          m_dm_wen = 1'b0, m_ps_wen = 1'b0;

    int n_run  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_dm_dt = '0; m_ps_dt = '0; m_dm_wen = 1'b0; m_ps_wen = 1'b0;
    endtask

    task automatic drive(input logic en, input logic [1:0] sc, input logic [DW-1:0] d, input logic rdy);
        ps_bc_do_en = en; ps_bc_do_sclt = sc; rf_bc_dt = d; xb_bc_rdy = rdy;
    endtask

    // One clock: advance the model with the inputs seen at the edge.
    task automatic tick();
        bit do_pop, do_push;
        @(posedge clk_dcd);
        if (reset) begin
            model_clear();
        end else begin
            do_pop  = (m_q.size() > 0) && xb_bc_rdy;
            do_push = ps_bc_do_en && ps_bc_do_sclt == 2'b10 && m_q.size() < DEPTH;
            m_dm_wen = ps_bc_do_en && ps_bc_do_sclt == 2'b00;
            m_ps_wen = ps_bc_do_en && ps_bc_do_sclt == 2'b01;
            if (m_dm_wen) m_dm_dt = rf_bc_dt;
            if (m_ps_wen) m_ps_dt = rf_bc_dt;
            if (do_pop) void'(m_q.pop_front());
            if (do_push) m_q.push_back({^rf_bc_dt, rf_bc_dt});
        end
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 8 && m_q.size() != 0; k++) begin
            drive(1'b0, 2'b00, '0, 1'b1);
            tick();
        end
        check("drain_bound", m_q.size(), 0);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk_dcd) begin
        check("dm_wen", bc_dm_wen, m_dm_wen);
        check("dm_dt", bc_dm_dt, m_dm_dt);
        check("ps_wen", bc_ps_wen, m_ps_wen);
        check("ps_dt", bc_ps_dt, m_ps_dt);
        check("xb_cnt", bc_xb_cnt, m_q.size());
        check("xb_vld", bc_xb_vld, m_q.size() != 0);
        check("stall", bc_ps_stall, m_q.size() == DEPTH);
        if (m_q.size() != 0) begin
            check("xb_dt", bc_xb_dt, m_q[0][DW-1:0]);
`ifdef BC_XB_PARITY_EN
            check("xb_par", bc_xb_par, m_q[0][DW]);
`endif
        end
    end

    initial begin
        repeat (3) tick();
        check("rst_cnt", bc_xb_cnt, 0);
        check("rst_vld", bc_xb_vld, 0);
        reset = 1'b0;

        // DM / PS routing
        drive(1'b1, 2'b00, 16'hA5A5, 1'b0); tick();
        check("lit_dm_wen", bc_dm_wen, 1);
        check("lit_dm_dt", bc_dm_dt, 16'hA5A5);
        check("lit_ps_wen0", bc_ps_wen, 0);
        drive(1'b1, 2'b01, 16'h1234, 1'b0); tick();
        check("lit_ps_wen", bc_ps_wen, 1);
        check("lit_ps_dt", bc_ps_dt, 16'h1234);
        check("lit_dm_wen0", bc_dm_wen, 0);
        check("lit_dm_hold", bc_dm_dt, 16'hA5A5);

        // Fill to full, ignored fifth push, then drain in order
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 2'b10, 16'(i), 1'b0); tick();
        end
        check("lit_full_stall", bc_ps_stall, 1);
        drive(1'b1, 2'b10, 16'h0005, 1'b0); tick();
        check("lit_full_cnt", bc_xb_cnt, 4);
        drive(1'b0, 2'b00, '0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            check("lit_head_seq", bc_xb_dt, i);
            tick();
        end
        check("lit_empty_vld", bc_xb_vld, 0);
        check("lit_empty_cnt", bc_xb_cnt, 0);

        // Concurrent push/pop at occupancy 2, pointers wrap
        drive(1'b1, 2'b10, 16'h0100, 1'b0); tick();
        drive(1'b1, 2'b10, 16'h0101, 1'b0); tick();
        for (int i = 2; i < 8; i++) begin
            drive(1'b1, 2'b10, 16'h0100 + 16'(i), 1'b1); tick();
        end
        check("lit_conc_cnt", bc_xb_cnt, 2);
        check("lit_conc_head", bc_xb_dt, 16'h0106);
        drain();

        // Back-pressure hold
        drive(1'b1, 2'b10, 16'hBEEF, 1'b0); tick();
        drive(1'b1, 2'b10, 16'h1111, 1'b0); tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 2'b00, '0, 1'b0); tick();
            check("lit_bp_hold", bc_xb_dt, 16'hBEEF);
        end
        drive(1'b0, 2'b00, '0, 1'b1); tick();
        drive(1'b0, 2'b00, '0, 1'b0);
        check("lit_bp_pop1", bc_xb_dt, 16'h1111);
        check("lit_bp_cnt", bc_xb_cnt, 1);

        // Asynchronous reset between edges
        drive(1'b1, 2'b10, 16'h2222, 1'b0); tick();
        drive(1'b1, 2'b10, 16'h3333, 1'b0); tick();
        drive(1'b0, 2'b00, '0, 1'b0);
        check("lit_pre_rst_cnt", bc_xb_cnt, 3);
        #2 reset = 1'b1;
        #1;
        model_clear();
        check("lit_arst_cnt", bc_xb_cnt, 0);
        check("lit_arst_vld", bc_xb_vld, 0);
        check("lit_arst_stall", bc_ps_stall, 0);
        check("lit_arst_dt", {bc_dm_dt, bc_ps_dt}, 0);
        check("lit_arst_wen", {bc_dm_wen, bc_ps_wen}, 0);
        tick();
        reset = 1'b0;
        drive(1'b1, 2'b10, 16'h00FF, 1'b0); tick();
        check("lit_post_rst_dt", bc_xb_dt, 16'h00FF);
        check("lit_post_rst_cnt", bc_xb_cnt, 1);

        // Discard code
        drive(1'b1, 2'b11, 16'hDEAD, 1'b0); tick();
        check("lit_disc_cnt", bc_xb_cnt, 1);
        check("lit_disc_wen", {bc_dm_wen, bc_ps_wen}, 0);
        drain();

`ifdef BC_XB_PARITY_EN
        drive(1'b1, 2'b10, 16'h0007, 1'b0); tick();
        check("lit_par1", bc_xb_par, 1);
        drive(1'b1, 2'b10, 16'h0003, 1'b1); tick();
        check("lit_par0", bc_xb_par, 0);
        drain();
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  16'($urandom), ($urandom_range(0, 2) == 0));
            tick();
        end

        drive(1'b0, 2'b00, '0, 1'b0);
        @(negedge clk_dcd);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
